// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, region decode, registered sync/de/rgb for the TMDS stage.
// Latency: pix_req/pix_x/pix_y combinational from counters; hsync/vsync/de/rgb/frame_start one sys_clk later.
// Backpressure: none; the raster never stalls, upstream must supply pix_data on the edge that closes a pix_req cycle.
// Optional: define TEST_PATTERN_EN to add pattern_sel and an 8-bar colour pattern source.
module video_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_VALID  = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_VALID  = 480,
  parameter int V_FRONT  = 10,
  parameter int SYNC_POL = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
`ifdef TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic [23:0] pix_data,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  rgb_red,
  output logic [7:0]  rgb_green,
  output logic [7:0]  rgb_blue,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
  localparam logic [11:0] H_START    = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_START    = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] H_END      = 12'(H_SYNC + H_BACK + H_VALID);
  localparam logic [11:0] V_END      = 12'(V_SYNC + V_BACK + V_VALID);

  // XOR mask turning an active-high region flag into the configured sync polarity
  localparam logic SYNC_INV = (SYNC_POL == 0);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        hs_act;
  logic        vs_act;
  logic        act;
  logic [23:0] rgb_src;

  // Horizontal counter: free-running 0..H_TOTAL-1
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Vertical counter: advances on each horizontal wrap, wraps after V_TOTAL lines
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 12'd1;
      end
    end
  end

  // Region decode on the live counters; pix_req leads the registered de by one cycle
  always_comb begin
    hs_act  = (h_cnt < H_SYNC_END);
    vs_act  = (v_cnt < V_SYNC_END);
    act     = (h_cnt >= H_START) && (h_cnt < H_END) &&
              (v_cnt >= V_START) && (v_cnt < V_END);
    pix_req = act;
    pix_x   = act ? (h_cnt - H_START) : '0;
    pix_y   = act ? (v_cnt - V_START) : '0;
  end

`ifdef TEST_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'(H_VALID / 8);

  logic [2:0] bar_idx;

  // Colour-bar source: white, yellow, cyan, green, magenta, red, blue, black.
  // With that ordering R = ~idx[1], G = ~idx[2], B = ~idx[0], so no lookup table is needed.
  always_comb begin
    bar_idx = 3'(pix_x / BAR_W);
    rgb_src = pattern_sel ? {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}}
                          : pix_data;
  end
`else
  // Pixel source is always the upstream frame buffer
  always_comb begin
    rgb_src = pix_data;
  end
`endif

  // Output stage: sync, de and rgb registered together so they stay aligned at the encoders
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= SYNC_INV;
      vsync       <= SYNC_INV;
      de          <= 1'b0;
      rgb_red     <= 8'd0;
      rgb_green   <= 8'd0;
      rgb_blue    <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_act ^ SYNC_INV;
      vsync       <= vs_act ^ SYNC_INV;
      de          <= act;
      rgb_red     <= act ? rgb_src[23:16] : 8'd0;
      rgb_green   <= act ? rgb_src[15:8]  : 8'd0;
      rgb_blue    <= act ? rgb_src[7:0]   : 8'd0;
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

endmodule
